rs_chien_seq: RTL

//  Sequential, parametrised Chien search for the RS decoder. Accepts one error-locator

---
 rtl/rs_chien_seq.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rs_chien_seq.sv
// -----------------------------------------------------------------------------
// rs_chien_seq
//   Sequential Chien search for the RS decoder. One error-locator polynomial
//   Lambda(x) is accepted per job. Codeword positions 0..N_LEN-1 are swept,
//   ROOTS_PER_CYCLE positions per beat. Position p is in error when
//   Lambda(alpha^-p) == 0. Per-beat error masks stream to the Forney stage.
//   Each job ends with a one-cycle summary: the saturated root count and a
//   decode-failure flag.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   loc_valid/ready job handshake; error_locator[j] = Lambda_j, loc_degree = deg
//   pos_valid/ready mask beat handshake; error_bit_pos[i] -> position b*R+i
//   pos_last        final beat of the job
//   done_valid      one-cycle pulse, root_count / decode_fail valid (held after)
// -----------------------------------------------------------------------------
module rs_chien_seq #(
  parameter int SYMB_WIDTH      = 8,
  parameter int T_LEN           = 8,
  parameter int N_LEN           = 255,
  parameter int ROOTS_PER_CYCLE = 4,
  localparam int CNT_W          = $clog2(T_LEN + 2)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 loc_valid,
  output logic                                 loc_ready,
  input  logic [T_LEN:0][SYMB_WIDTH-1:0]       error_locator,
  input  logic [CNT_W-1:0]                     loc_degree,
  output logic                                 pos_valid,
  input  logic                                 pos_ready,
  output logic [ROOTS_PER_CYCLE-1:0]           error_bit_pos,
  output logic                                 pos_last,
  output logic                                 done_valid,
  output logic [CNT_W-1:0]                     root_count,
  output logic                                 decode_fail
);

  localparam int R         = ROOTS_PER_CYCLE;
  localparam int NUM_BEATS = (N_LEN + R - 1) / R;
  localparam int BEAT_W    = $clog2(NUM_BEATS + 1);
  localparam int FIELD     = (1 << SYMB_WIDTH) - 1;
  localparam int SW1       = SYMB_WIDTH + 1;

  typedef logic [T_LEN:0][SYMB_WIDTH-1:0] coef_t;
  typedef logic [FIELD-1:0][SYMB_WIDTH-1:0] pow_tbl_t;
  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} state_t;

  // Primitive polynomial (including the x^m term) defining the field.
  function automatic int prim_poly(input int m);
    case (m)
      2:       return 32'h0000_0007;
      3:       return 32'h0000_000B;
      4:       return 32'h0000_0013;
      5:       return 32'h0000_0025;
      6:       return 32'h0000_0043;
      7:       return 32'h0000_0089;
      8:       return 32'h0000_011D;
      9:       return 32'h0000_0211;
      10:      return 32'h0000_0409;
      11:      return 32'h0000_0805;
      12:      return 32'h0000_1053;
      default: return 32'h0000_011D;
    endcase
  endfunction

  localparam int POLY_INT = prim_poly(SYMB_WIDTH);

  // Multiply by alpha (= x): shift, then reduce by the primitive polynomial.
  function automatic logic [SYMB_WIDTH-1:0] mul_x(input logic [SYMB_WIDTH-1:0] a);
    logic [SYMB_WIDTH:0] wide;
    wide = {a, 1'b0};
    if (wide[SYMB_WIDTH]) begin
      wide = wide ^ SW1'(POLY_INT);
    end else begin
      wide = wide;
    end
    return wide[SYMB_WIDTH-1:0];
  endfunction

  // Generic GF(2^m) shift-and-add multiplier.
  function automatic logic [SYMB_WIDTH-1:0] gf_mult(input logic [SYMB_WIDTH-1:0] a,
                                                    input logic [SYMB_WIDTH-1:0] b);
    logic [SYMB_WIDTH-1:0] prod;
    logic [SYMB_WIDTH-1:0] aa;
    prod = '0;
    aa   = a;
    for (int k = 0; k < SYMB_WIDTH; k++) begin
      if (b[k]) begin
        prod = prod ^ aa;
      end else begin
        prod = prod;
      end
      aa = mul_x(aa);
    end
    return prod;
  endfunction

  // Elaboration-time table alpha^0 .. alpha^(FIELD-1).
  function automatic pow_tbl_t gen_alpha_pow();
    pow_tbl_t              tbl;
    logic [SYMB_WIDTH-1:0] a;
    a = SYMB_WIDTH'(1);
    for (int k = 0; k < FIELD; k++) begin
      tbl[k] = a;
      a      = mul_x(a);
    end
    return tbl;
  endfunction

  localparam pow_tbl_t ALPHA_POW = gen_alpha_pow();

  // alpha^(-k); every call site has a constant k, so this folds to a constant.
  function automatic logic [SYMB_WIDTH-1:0] alpha_inv(input int k);
    int idx;
    idx = (FIELD - (k % FIELD)) % FIELD;
    return ALPHA_POW[idx];
  endfunction

  // Evaluate one beat: bit i set when sum_j T_j*alpha^(-j*i) == 0 and the
  // position lies inside the codeword (tail padding reads as no-error).
  function automatic logic [R-1:0] eval_mask(input coef_t src, input int beat);
    logic [R-1:0]          mask;
    logic [SYMB_WIDTH-1:0] sum;
    mask = '0;
    for (int i = 0; i < R; i++) begin
      sum = '0;
      for (int j = 0; j <= T_LEN; j++) begin
        sum = sum ^ gf_mult(src[j], alpha_inv(j * i));
      end
      mask[i] = (sum == '0) && ((beat * R + i) < N_LEN);
    end
    return mask;
  endfunction

  function automatic int popcount(input logic [R-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < R; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

  state_t             state_q, state_d;
  coef_t              term_q, term_d, term_next, eval_src;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]   acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0]   deg_q, deg_d;
  logic               bad_q, bad_d;
  logic [R-1:0]       mask_q, mask_d, mask_eval;
  logic               pv_q, pv_d, pl_q, pl_d, dv_q, dv_d, df_q, df_d, lr_q, lr_d;
  logic [CNT_W-1:0]   rc_q, rc_d;
  logic               accept;
  int                 eval_beat;
  int                 sum_int;

  assign accept = loc_valid && lr_q;

  // Datapath: advanced terms, shared evaluator input selection, saturating count.
  always_comb begin
    for (int j = 0; j <= T_LEN; j++) begin
      term_next[j] = gf_mult(term_q[j], alpha_inv(j * R));
    end
    // On accept the first beat is evaluated straight from the incoming locator.
    if (accept) begin
      eval_src  = error_locator;
      eval_beat = 0;
    end else begin
      eval_src  = term_next;
      eval_beat = int'(beat_q) + 1;
    end
    mask_eval = eval_mask(eval_src, eval_beat);
    sum_int   = int'(acc_q) + popcount(mask_q);
    if (sum_int > T_LEN + 1) begin
      sum_int = T_LEN + 1;
    end else begin
      sum_int = sum_int;
    end
    acc_sum = CNT_W'(sum_int);
  end

  // FSM next-state and registered-output next values.
  always_comb begin
    state_d = state_q;
    term_d  = term_q;
    beat_d  = beat_q;
    acc_d   = acc_q;
    deg_d   = deg_q;
    bad_d   = bad_q;
    mask_d  = mask_q;
    pv_d    = pv_q;
    pl_d    = pl_q;
    dv_d    = 1'b0;
    rc_d    = rc_q;
    df_d    = df_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          term_d  = error_locator;
          beat_d  = '0;
          acc_d   = '0;
          deg_d   = loc_degree;
          bad_d   = (error_locator[0] == '0) || (int'(loc_degree) > T_LEN);
          mask_d  = mask_eval;
          pv_d    = 1'b1;
          pl_d    = (NUM_BEATS == 1);
          state_d = SEARCH;
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        if (pos_ready) begin
          acc_d = acc_sum;
          if (pl_q) begin
            state_d = DONE;
            pv_d    = 1'b0;
            pl_d    = 1'b0;
            mask_d  = '0;
            dv_d    = 1'b1;
            rc_d    = acc_sum;
            df_d    = bad_q || (acc_sum != deg_q);
          end else begin
            term_d = term_next;
            beat_d = beat_q + BEAT_W'(1);
            mask_d = mask_eval;
            pl_d   = ((int'(beat_q) + 1) == (NUM_BEATS - 1));
          end
        end else begin
          state_d = SEARCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    lr_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      term_q  <= '0;
      beat_q  <= '0;
      acc_q   <= '0;
      deg_q   <= '0;
      bad_q   <= 1'b0;
      mask_q  <= '0;
      pv_q    <= 1'b0;
      pl_q    <= 1'b0;
      dv_q    <= 1'b0;
      rc_q    <= '0;
      df_q    <= 1'b0;
      lr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
      beat_q  <= beat_d;
      acc_q   <= acc_d;
      deg_q   <= deg_d;
      bad_q   <= bad_d;
      mask_q  <= mask_d;
      pv_q    <= pv_d;
      pl_q    <= pl_d;
      dv_q    <= dv_d;
      rc_q    <= rc_d;
      df_q    <= df_d;
      lr_q    <= lr_d;
    end
  end

  assign loc_ready     = lr_q;
  assign pos_valid     = pv_q;
  assign error_bit_pos = mask_q;
  assign pos_last      = pl_q;
  assign done_valid    = dv_q;
  assign root_count    = rc_q;
  assign decode_fail   = df_q;

endmodule
